// File: rtl/reg_file_scoreboard.sv
// Register file with a per-register busy scoreboard: one decoded write port,
// two registered read ports with write-through bypass, optional hardwired zero register.
module reg_file_scoreboard #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     WR_EN,
  input  logic [ADDR_W-1:0]        WR_ADDR,
  input  logic [WIDTH-1:0]         WR_DATA,
  input  logic                     RD_EN_A,
  input  logic [ADDR_W-1:0]        RD_ADDR_A,
  output logic [WIDTH-1:0]         RD_DATA_A,
  output logic                     RD_BUSY_A,
  input  logic                     RD_EN_B,
  input  logic [ADDR_W-1:0]        RD_ADDR_B,
  output logic [WIDTH-1:0]         RD_DATA_B,
  output logic                     RD_BUSY_B,
  input  logic                     RSV_EN,
  input  logic [ADDR_W-1:0]        RSV_ADDR,
  output logic [(2**ADDR_W)-1:0]   BUSY,
  output logic                     RSV_ERR
);

  localparam int unsigned DEPTH    = 2**ADDR_W;
  localparam bit          HAS_ZERO = (ZERO_REG != 0);

  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [WIDTH-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0] busy_q, busy_d;
  logic [DEPTH-1:0] wr_sel, rsv_sel;
  logic [WIDTH-1:0] rd_data_a_q, rd_data_a_d;
  logic [WIDTH-1:0] rd_data_b_q, rd_data_b_d;
  logic             rd_busy_a_q, rd_busy_a_d;
  logic             rd_busy_b_q, rd_busy_b_d;
  logic             rsv_err_q, rsv_err_d;

  // One-hot write and reserve decode; register 0 is masked out when hardwired to zero
  always_comb begin
    wr_sel  = '0;
    rsv_sel = '0;
    if (WR_EN)  wr_sel[WR_ADDR]   = 1'b1;
    if (RSV_EN) rsv_sel[RSV_ADDR] = 1'b1;
    if (HAS_ZERO) begin
      wr_sel[0]  = 1'b0;
      rsv_sel[0] = 1'b0;
    end
  end

  // Register array, scoreboard and reservation-error next state
  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      regs_d[i] = wr_sel[i] ? WR_DATA : regs_q[i];
    end
    // a same-cycle reservation wins over the clearing write
    busy_d    = (busy_q & ~wr_sel) | rsv_sel;
    rsv_err_d = |(rsv_sel & busy_q & ~wr_sel);
  end

  // Read port A: zero register, then write bypass, then stored value
  always_comb begin
    rd_data_a_d = rd_data_a_q;
    rd_busy_a_d = rd_busy_a_q;
    if (RD_EN_A) begin
      rd_busy_a_d = busy_d[RD_ADDR_A];
      if (HAS_ZERO && (RD_ADDR_A == '0)) begin
        rd_data_a_d = '0;
      end else if (wr_sel[RD_ADDR_A]) begin
        rd_data_a_d = WR_DATA;
      end else begin
        rd_data_a_d = regs_q[RD_ADDR_A];
      end
    end
  end

  // Read port B: same selection as port A, fully independent
  always_comb begin
    rd_data_b_d = rd_data_b_q;
    rd_busy_b_d = rd_busy_b_q;
    if (RD_EN_B) begin
      rd_busy_b_d = busy_d[RD_ADDR_B];
      if (HAS_ZERO && (RD_ADDR_B == '0)) begin
        rd_data_b_d = '0;
      end else if (wr_sel[RD_ADDR_B]) begin
        rd_data_b_d = WR_DATA;
      end else begin
        rd_data_b_d = regs_q[RD_ADDR_B];
      end
    end
  end

  // State registers; synchronous reset overrides every same-cycle request
  always_ff @(posedge CLK) begin
    if (RESET) begin
      regs_q      <= '{default: '0};
      busy_q      <= '0;
      rd_data_a_q <= '0;
      rd_data_b_q <= '0;
      rd_busy_a_q <= 1'b0;
      rd_busy_b_q <= 1'b0;
      rsv_err_q   <= 1'b0;
    end else begin
      regs_q      <= regs_d;
      busy_q      <= busy_d;
      rd_data_a_q <= rd_data_a_d;
      rd_data_b_q <= rd_data_b_d;
      rd_busy_a_q <= rd_busy_a_d;
      rd_busy_b_q <= rd_busy_b_d;
      rsv_err_q   <= rsv_err_d;
    end
  end

  assign RD_DATA_A = rd_data_a_q;
  assign RD_DATA_B = rd_data_b_q;
  assign RD_BUSY_A = rd_busy_a_q;
  assign RD_BUSY_B = rd_busy_b_q;
  assign BUSY      = busy_q;
  assign RSV_ERR   = rsv_err_q;

endmodule

// File: tb/tb_reg_file_scoreboard.sv
// Self-checking bench for reg_file_scoreboard: directed scenarios plus a
// randomized run against a behavioural model of the register file and scoreboard.
module tb_reg_file_scoreboard;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        WR_EN;
  logic [4:0]  WR_ADDR;
  logic [31:0] WR_DATA;
  logic        RD_EN_A;
  logic [4:0]  RD_ADDR_A;
  logic [31:0] RD_DATA_A;
  logic        RD_BUSY_A;
  logic        RD_EN_B;
  logic [4:0]  RD_ADDR_B;
  logic [31:0] RD_DATA_B;
  logic        RD_BUSY_B;
  logic        RSV_EN;
  logic [4:0]  RSV_ADDR;
  logic [31:0] BUSY;
  logic        RSV_ERR;

  int passed = 0;
  int total  = 0;

  // behavioural model state
  logic [31:0] m_regs [32];
  logic [31:0] m_busy;
  logic [31:0] m_rd_a, m_rd_b;
  logic        m_rb_a, m_rb_b, m_err;

  reg_file_scoreboard #(.WIDTH(32), .ADDR_W(5), .ZERO_REG(1)) dut (
    .CLK(CLK), .RESET(RESET),
    .WR_EN(WR_EN), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA),
    .RD_EN_A(RD_EN_A), .RD_ADDR_A(RD_ADDR_A), .RD_DATA_A(RD_DATA_A), .RD_BUSY_A(RD_BUSY_A),
    .RD_EN_B(RD_EN_B), .RD_ADDR_B(RD_ADDR_B), .RD_DATA_B(RD_DATA_B), .RD_BUSY_B(RD_BUSY_B),
    .RSV_EN(RSV_EN), .RSV_ADDR(RSV_ADDR), .BUSY(BUSY), .RSV_ERR(RSV_ERR)
  );

  always #5 CLK = ~CLK;

  // value a read of addr sees this cycle: zero register, bypass, else stored
  function automatic logic [31:0] model_read(input logic [4:0] addr);
    if (addr == 5'd0) return 32'd0;
    if (WR_EN && (WR_ADDR == addr)) return WR_DATA;
    return m_regs[addr];
  endfunction

  // advance the model by one clock edge using the inputs currently applied
  task automatic model_step();
    logic [31:0] nb;
    if (RESET) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
      m_busy = 32'd0; m_rd_a = 32'd0; m_rd_b = 32'd0;
      m_rb_a = 1'b0; m_rb_b = 1'b0; m_err = 1'b0;
    end else begin
      nb = m_busy;
      if (WR_EN) nb[WR_ADDR] = 1'b0;
      if (RSV_EN && RSV_ADDR != 5'd0) nb[RSV_ADDR] = 1'b1;
      m_err = RSV_EN && (RSV_ADDR != 5'd0) && m_busy[RSV_ADDR]
              && !(WR_EN && (WR_ADDR == RSV_ADDR));
      if (RD_EN_A) begin m_rd_a = model_read(RD_ADDR_A); m_rb_a = nb[RD_ADDR_A]; end
      if (RD_EN_B) begin m_rd_b = model_read(RD_ADDR_B); m_rb_b = nb[RD_ADDR_B]; end
      if (WR_EN && WR_ADDR != 5'd0) m_regs[WR_ADDR] = WR_DATA;
      m_busy = nb;
    end
  endtask

  task automatic idle();
    RESET = 1'b0; WR_EN = 1'b0; WR_ADDR = '0; WR_DATA = '0;
    RD_EN_A = 1'b0; RD_ADDR_A = '0; RD_EN_B = 1'b0; RD_ADDR_B = '0;
    RSV_EN = 1'b0; RSV_ADDR = '0;
  endtask

  task automatic cycle();
    model_step();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    idle(); RESET = 1'b1; cycle(); cycle();
    idle();
    total++; if (RD_DATA_A !== 32'd0 || RD_DATA_B !== 32'd0) $display("FAIL reset_rd_data A=%h B=%h want 0", RD_DATA_A, RD_DATA_B); else passed++;
    total++; if (BUSY !== 32'd0 || RSV_ERR !== 1'b0 || RD_BUSY_A !== 1'b0 || RD_BUSY_B !== 1'b0)
      $display("FAIL reset_flags BUSY=%h ERR=%b RBA=%b RBB=%b want 0", BUSY, RSV_ERR, RD_BUSY_A, RD_BUSY_B); else passed++;
    WR_EN = 1'b1; WR_ADDR = 5'd5; WR_DATA = 32'hAAAA_AAAA; cycle();
    idle(); RESET = 1'b1; cycle();
    idle(); RD_EN_A = 1'b1; RD_ADDR_A = 5'd5; cycle();
    idle();
    total++; if (RD_DATA_A !== 32'd0) $display("FAIL reset_clears_r5 got=%h want=0", RD_DATA_A); else passed++;
    total++; if (BUSY !== 32'd0 || RSV_ERR !== 1'b0) $display("FAIL reset_busy BUSY=%h ERR=%b want 0", BUSY, RSV_ERR); else passed++;
  endtask

  task automatic test_decode_sweep();
    logic [31:0] exp_a, exp_b;
    for (int i = 1; i < 32; i++) begin
      idle(); WR_EN = 1'b1; WR_ADDR = 5'(i); WR_DATA = 32'(i + 1); cycle();
    end
    idle(); WR_EN = 1'b1; WR_ADDR = 5'd0; WR_DATA = 32'hFFFF_FFFF; cycle();
    for (int i = 0; i < 32; i++) begin
      idle(); RD_EN_A = 1'b1; RD_ADDR_A = 5'(i); RD_EN_B = 1'b1; RD_ADDR_B = 5'(31 - i); cycle();
      exp_a = (i == 0) ? 32'd0 : 32'(i + 1);
      exp_b = (i == 31) ? 32'd0 : 32'(32 - i);
      total++; if (RD_DATA_A !== exp_a) $display("FAIL sweep_a r%0d got=%h want=%h", i, RD_DATA_A, exp_a); else passed++;
      total++; if (RD_DATA_B !== exp_b) $display("FAIL sweep_b r%0d got=%h want=%h", 31 - i, RD_DATA_B, exp_b); else passed++;
    end
    idle();
  endtask

  task automatic test_bypass();
    idle(); WR_EN = 1'b1; WR_ADDR = 5'd7; WR_DATA = 32'h5555_5555;
    RD_EN_A = 1'b1; RD_ADDR_A = 5'd7; RD_EN_B = 1'b1; RD_ADDR_B = 5'd7; cycle();
    total++; if (RD_DATA_A !== 32'h5555_5555) $display("FAIL bypass_a got=%h want=55555555", RD_DATA_A); else passed++;
    total++; if (RD_DATA_B !== 32'h5555_5555) $display("FAIL bypass_b got=%h want=55555555", RD_DATA_B); else passed++;
    idle(); RD_ADDR_A = 5'd3; RD_EN_B = 1'b1; RD_ADDR_B = 5'd5; cycle();
    total++; if (RD_DATA_A !== 32'h5555_5555) $display("FAIL hold_a got=%h want=55555555", RD_DATA_A); else passed++;
    total++; if (RD_DATA_B !== 32'd6) $display("FAIL read_b_r5 got=%h want=6", RD_DATA_B); else passed++;
    idle();
  endtask

  task automatic test_scoreboard();
    idle(); RSV_EN = 1'b1; RSV_ADDR = 5'd3; cycle();
    total++; if (BUSY !== 32'h0000_0008 || RSV_ERR !== 1'b0) $display("FAIL rsv_r3 BUSY=%h ERR=%b want 00000008/0", BUSY, RSV_ERR); else passed++;
    idle(); RD_EN_A = 1'b1; RD_ADDR_A = 5'd3; cycle();
    total++; if (RD_BUSY_A !== 1'b1 || RD_DATA_A !== 32'd4) $display("FAIL rd_busy_r3 busy=%b data=%h want 1/4", RD_BUSY_A, RD_DATA_A); else passed++;
    idle(); WR_EN = 1'b1; WR_ADDR = 5'd3; WR_DATA = 32'h1234_5678; RD_EN_A = 1'b1; RD_ADDR_A = 5'd3; cycle();
    total++; if (BUSY[3] !== 1'b0) $display("FAIL wb_clear BUSY=%h want bit3=0", BUSY); else passed++;
    total++; if (RD_BUSY_A !== 1'b0 || RD_DATA_A !== 32'h1234_5678) $display("FAIL wb_read busy=%b data=%h want 0/12345678", RD_BUSY_A, RD_DATA_A); else passed++;
    idle(); RSV_EN = 1'b1; RSV_ADDR = 5'd0; cycle();
    total++; if (BUSY !== 32'd0 || RSV_ERR !== 1'b0) $display("FAIL rsv_r0 BUSY=%h ERR=%b want 0/0", BUSY, RSV_ERR); else passed++;
    idle(); RSV_EN = 1'b1; RSV_ADDR = 5'd0; cycle();
    total++; if (RSV_ERR !== 1'b0) $display("FAIL rsv_r0_twice ERR=%b want 0", RSV_ERR); else passed++;
    idle();
  endtask

  task automatic test_collision();
    idle(); RSV_EN = 1'b1; RSV_ADDR = 5'd9; cycle();
    total++; if (BUSY !== 32'h0000_0200) $display("FAIL rsv_r9 BUSY=%h want 00000200", BUSY); else passed++;
    idle(); RSV_EN = 1'b1; RSV_ADDR = 5'd9; WR_EN = 1'b1; WR_ADDR = 5'd9; WR_DATA = 32'h0000_0099; cycle();
    total++; if (BUSY[9] !== 1'b1 || RSV_ERR !== 1'b0) $display("FAIL collide BUSY=%h ERR=%b want bit9=1/0", BUSY, RSV_ERR); else passed++;
    idle(); RSV_EN = 1'b1; RSV_ADDR = 5'd9; cycle();
    total++; if (RSV_ERR !== 1'b1 || BUSY[9] !== 1'b1) $display("FAIL rsv_err_pulse ERR=%b BUSY=%h want 1/bit9=1", RSV_ERR, BUSY); else passed++;
    idle(); RD_EN_B = 1'b1; RD_ADDR_B = 5'd9; cycle();
    total++; if (RSV_ERR !== 1'b0) $display("FAIL rsv_err_one_cycle ERR=%b want 0", RSV_ERR); else passed++;
    total++; if (RD_DATA_B !== 32'h0000_0099 || RD_BUSY_B !== 1'b1) $display("FAIL read_r9 data=%h busy=%b want 99/1", RD_DATA_B, RD_BUSY_B); else passed++;
    idle();
  endtask

  task automatic test_reset_mid();
    idle(); RESET = 1'b1; WR_EN = 1'b1; WR_ADDR = 5'd12; WR_DATA = 32'hDEAD_BEEF;
    RSV_EN = 1'b1; RSV_ADDR = 5'd12; RD_EN_A = 1'b1; RD_ADDR_A = 5'd12; RD_EN_B = 1'b1; RD_ADDR_B = 5'd9; cycle();
    total++; if (RD_DATA_A !== 32'd0 || RD_DATA_B !== 32'd0 || RD_BUSY_A !== 1'b0 || RD_BUSY_B !== 1'b0)
      $display("FAIL midreset_rd A=%h B=%h RBA=%b RBB=%b want 0", RD_DATA_A, RD_DATA_B, RD_BUSY_A, RD_BUSY_B); else passed++;
    total++; if (BUSY !== 32'd0 || RSV_ERR !== 1'b0) $display("FAIL midreset_busy BUSY=%h ERR=%b want 0", BUSY, RSV_ERR); else passed++;
    idle(); RD_EN_A = 1'b1; RD_ADDR_A = 5'd12; cycle();
    total++; if (RD_DATA_A !== 32'd0 || RD_BUSY_A !== 1'b0) $display("FAIL midreset_write_lost data=%h busy=%b want 0/0", RD_DATA_A, RD_BUSY_A); else passed++;
    idle();
  endtask

  // random traffic biased to a few registers so collisions and bypasses occur often
  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      idle();
      RESET     = ($urandom_range(0, 63) == 0);
      WR_EN     = $urandom_range(0, 1) == 1;
      WR_ADDR   = $urandom_range(0, 1) == 1 ? 5'($urandom_range(0, 5)) : 5'($urandom_range(0, 31));
      WR_DATA   = $urandom;
      RD_EN_A   = $urandom_range(0, 3) != 0;
      RD_ADDR_A = $urandom_range(0, 1) == 1 ? 5'($urandom_range(0, 5)) : 5'($urandom_range(0, 31));
      RD_EN_B   = $urandom_range(0, 3) != 0;
      RD_ADDR_B = $urandom_range(0, 1) == 1 ? 5'($urandom_range(0, 5)) : 5'($urandom_range(0, 31));
      RSV_EN    = $urandom_range(0, 1) == 1;
      RSV_ADDR  = $urandom_range(0, 1) == 1 ? 5'($urandom_range(0, 5)) : 5'($urandom_range(0, 31));
      cycle();
      total++; if (RD_DATA_A !== m_rd_a) $display("FAIL rand_rd_a n=%0d got=%h want=%h", n, RD_DATA_A, m_rd_a); else passed++;
      total++; if (RD_DATA_B !== m_rd_b) $display("FAIL rand_rd_b n=%0d got=%h want=%h", n, RD_DATA_B, m_rd_b); else passed++;
      total++; if (RD_BUSY_A !== m_rb_a) $display("FAIL rand_busy_a n=%0d got=%b want=%b", n, RD_BUSY_A, m_rb_a); else passed++;
      total++; if (RD_BUSY_B !== m_rb_b) $display("FAIL rand_busy_b n=%0d got=%b want=%b", n, RD_BUSY_B, m_rb_b); else passed++;
      total++; if (BUSY !== m_busy) $display("FAIL rand_busy_mask n=%0d got=%h want=%h", n, BUSY, m_busy); else passed++;
      total++; if (RSV_ERR !== m_err) $display("FAIL rand_rsv_err n=%0d got=%b want=%b", n, RSV_ERR, m_err); else passed++;
    end
    idle();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    m_busy = 32'd0; m_rd_a = 32'd0; m_rd_b = 32'd0;
    m_rb_a = 1'b0; m_rb_b = 1'b0; m_err = 1'b0;
    idle();
    test_reset();
    test_decode_sweep();
    test_bypass();
    test_scoreboard();
    test_collision();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
